// File: rtl/colide_scan_pkg.sv
// Shared types for the collision scanner: obstacle record,
// default obstacle table, FSM states and the overlap test.
package colide_pkg;

  typedef struct packed {
    logic [9:0] ini_x;
    logic [9:0] fin_x;
    logic [9:0] ini_y;
    logic [9:0] fin_y;
  } obst_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int N_TABLE = 10;

  // Obstacles 3 and 7 share the patch x 55..60, y 320..330.
  localparam obst_t OBST_TABLE [N_TABLE] = '{
    '{10'd100, 10'd350, 10'd100, 10'd110},
    '{10'd400, 10'd420, 10'd200, 10'd260},
    '{10'd500, 10'd600, 10'd20,  10'd40 },
    '{10'd30,  10'd60,  10'd300, 10'd330},
    '{10'd600, 10'd630, 10'd400, 10'd450},
    '{10'd150, 10'd200, 10'd400, 10'd420},
    '{10'd250, 10'd300, 10'd250, 10'd280},
    '{10'd55,  10'd90,  10'd320, 10'd350},
    '{10'd450, 10'd480, 10'd300, 10'd310},
    '{10'd300, 10'd310, 10'd420, 10'd470}
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Half-open interval overlap, strict on both ends.
  function automatic logic overlap(
    input logic [10:0] a_lo,
    input logic [10:0] a_hi,
    input logic [10:0] b_lo,
    input logic [10:0] b_hi
  );
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

endpackage

// File: rtl/colide_scan_if.sv
// Request/result bundle of the collision scanner.
// master drives start/geometry; slave returns busy/done/flags.
interface colide_scan_if
  import colide_pkg::*;
#(
  parameter int N_OBST = 10
);
  localparam int IW = idx_w(N_OBST);

  logic          start;
  logic [6:0]    tamanho;
  logic [9:0]    xPos;
  logic [8:0]    yPos;
  logic          busy;
  logic          done;
  logic          colisao_max_y;
  logic          colisao_min_y;
  logic          colisao_max_x;
  logic          colisao_min_x;
  logic [IW-1:0] hit_idx;

  modport master (
    output start, tamanho, xPos, yPos,
    input  busy, done, hit_idx,
    input  colisao_max_y, colisao_min_y,
    input  colisao_max_x, colisao_min_x
  );

  modport slave (
    input  start, tamanho, xPos, yPos,
    output busy, done, hit_idx,
    output colisao_max_y, colisao_min_y,
    output colisao_max_x, colisao_min_x
  );
endinterface

// File: rtl/colide_scan_rom.sv
// Combinational obstacle table lookup.
// idx: obstacle index in; rec: rectangle out (zero past table end).
module obstaculo_rom
  import colide_pkg::*;
(
  input  logic [5:0] idx,
  output obst_t      rec
);
  always_comb begin
    rec = '0;
    for (int k = 0; k < N_TABLE; k++) begin
      if (idx == 6'(k)) rec = OBST_TABLE[k];
    end
  end
endmodule

// File: rtl/colide_scan.sv
// Sequential collision scanner: one obstacle per cycle.
// Ports: VGA_clk, reset (sync, high), bus (colide_scan_if.slave).
module colide_scan
  import colide_pkg::*;
#(
  parameter int N_OBST = 10,
  parameter int STEP   = 1,
  parameter int H_MAX  = 640,
  parameter int V_MAX  = 480
)(
  input logic           VGA_clk,
  input logic           reset,
  colide_scan_if.slave  bus
);
  localparam int IW = idx_w(N_OBST);
  localparam int CW = $clog2(N_OBST + 1);

  localparam logic [10:0] S  = 11'(STEP);
  localparam logic [10:0] HM = 11'(H_MAX);
  localparam logic [10:0] VM = 11'(V_MAX);

  state_t state, nxt;

  logic [9:0]    x_q;
  logic [8:0]    y_q;
  logic [6:0]    t_q;
  logic [CW-1:0] rd_idx;
  logic          ev_vld;
  logic [IW-1:0] ev_idx;
  obst_t         obs_q;
  obst_t         rom_rec;
  logic [3:0]    acc;
  logic          hit_any;
  logic [IW-1:0] hit_acc;
  logic [3:0]    flags_q;
  logic [IW-1:0] hit_q;
  logic          done_q;

  logic [10:0] x_lo, x_hi, y_lo, y_hi;
  logic [10:0] ox_lo, ox_hi, oy_lo, oy_hi;
  logic        ov_x, ov_y;
  logic [3:0]  cur;
  logic [3:0]  edge_b;
  logic        last;

  obstaculo_rom u_rom (
    .idx (6'(rd_idx)),
    .rec (rom_rec)
  );

  // Flag order: {max_y, min_y, max_x, min_x}.
  // Up/left shift the obstacle instead of the object so
  // nothing underflows near the screen origin.
  always_comb begin
    x_lo  = {1'b0, x_q};
    x_hi  = x_lo + 11'(t_q);
    y_lo  = {2'b0, y_q};
    y_hi  = y_lo + 11'(t_q);
    ox_lo = {1'b0, obs_q.ini_x};
    ox_hi = {1'b0, obs_q.fin_x};
    oy_lo = {1'b0, obs_q.ini_y};
    oy_hi = {1'b0, obs_q.fin_y};
    ov_x  = overlap(x_lo, x_hi, ox_lo, ox_hi);
    ov_y  = overlap(y_lo, y_hi, oy_lo, oy_hi);
    cur   = '0;
    if (ev_vld && (t_q != '0)) begin
      cur[3] = ov_x &&
        overlap(y_lo + S, y_hi + S, oy_lo, oy_hi);
      cur[2] = ov_x &&
        overlap(y_lo, y_hi, oy_lo + S, oy_hi + S);
      cur[1] = ov_y &&
        overlap(x_lo + S, x_hi + S, ox_lo, ox_hi);
      cur[0] = ov_y &&
        overlap(x_lo, x_hi, ox_lo + S, ox_hi + S);
    end
    edge_b[3] = (y_hi + S) > VM;
    edge_b[2] = y_lo < S;
    edge_b[1] = (x_hi + S) > HM;
    edge_b[0] = x_lo < S;
    last = ev_vld && (ev_idx == IW'(N_OBST - 1));
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = SCAN;
      SCAN:    if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // ROM read is registered; evaluation runs one cycle behind
  // the read index.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      rd_idx  <= '0;
      ev_vld  <= 1'b0;
      ev_idx  <= '0;
      obs_q   <= '0;
      acc     <= '0;
      hit_any <= 1'b0;
      hit_acc <= '0;
      flags_q <= '0;
      hit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == SCAN) && last;
      if ((state == IDLE) && bus.start) begin
        x_q     <= bus.xPos;
        y_q     <= bus.yPos;
        t_q     <= bus.tamanho;
        rd_idx  <= '0;
        ev_vld  <= 1'b0;
        acc     <= '0;
        hit_any <= 1'b0;
        hit_acc <= '0;
      end
      if (state == SCAN) begin
        if (rd_idx < CW'(N_OBST)) begin
          obs_q  <= rom_rec;
          ev_idx <= IW'(rd_idx);
          ev_vld <= 1'b1;
          rd_idx <= rd_idx + 1'b1;
        end else begin
          ev_vld <= 1'b0;
        end
        if (ev_vld) begin
          acc <= acc | cur;
          if (!hit_any && (|cur)) begin
            hit_any <= 1'b1;
            hit_acc <= ev_idx;
          end
        end
        if (last) begin
          flags_q <= acc | cur | edge_b;
          if (hit_any)     hit_q <= hit_acc;
          else if (|cur)   hit_q <= ev_idx;
          else             hit_q <= '0;
        end
      end
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.colisao_max_y = flags_q[3];
  assign bus.colisao_min_y = flags_q[2];
  assign bus.colisao_max_x = flags_q[1];
  assign bus.colisao_min_x = flags_q[0];
  assign bus.hit_idx       = hit_q;

endmodule

// File: tb/tb_colide_scan.sv
// Self-checking bench for colide_scan against a geometric
// reference model (object shifted by a signed step vector).
module tb_colide_scan;

  localparam int STEP = 1;
  localparam int HMAX = 640;
  localparam int VMAX = 480;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  colide_scan_if #(.N_OBST(10)) bus ();
  colide_scan_if #(.N_OBST(1))  bus1 ();

  colide_scan #(.N_OBST(10), .STEP(STEP)) u_dut (
    .VGA_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  colide_scan #(.N_OBST(1), .STEP(STEP)) u_dut1 (
    .VGA_clk (clk),
    .reset   (reset),
    .bus     (bus1)
  );

  int OX0 [10] = '{100, 400, 500, 30, 600, 150, 250, 55, 450, 300};
  int OX1 [10] = '{350, 420, 600, 60, 630, 200, 300, 90, 480, 310};
  int OY0 [10] = '{100, 200, 20, 300, 400, 400, 250, 320, 300, 420};
  int OY1 [10] = '{110, 260, 40, 330, 450, 420, 280, 350, 310, 470};

  int nvec = 0;
  int nerr = 0;

  // Returns {hit[5:0], max_y, min_y, max_x, min_x}.
  function automatic logic [9:0] model(input int n, input int x,
                                       input int y, input int t);
    int dx [4];
    int dy [4];
    logic [3:0] f;
    int hit;
    dx = '{0, 0, STEP, -STEP};
    dy = '{STEP, -STEP, 0, 0};
    f = '0;
    hit = -1;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 4; d++) begin
        int ax0, ax1, ay0, ay1;
        ax0 = x + dx[d];
        ax1 = x + t + dx[d];
        ay0 = y + dy[d];
        ay1 = y + t + dy[d];
        if (t > 0 && ax0 < OX1[i] && OX0[i] < ax1 &&
            ay0 < OY1[i] && OY0[i] < ay1) begin
          f[3-d] = 1'b1;
          if (hit < 0) hit = i;
        end
      end
    end
    if (y + t + STEP > VMAX) f[3] = 1'b1;
    if (y < STEP)            f[2] = 1'b1;
    if (x + t + STEP > HMAX) f[1] = 1'b1;
    if (x < STEP)            f[0] = 1'b1;
    if (hit < 0) hit = 0;
    return {6'(hit), f};
  endfunction

  function automatic logic [9:0] obs0();
    return {6'(bus.hit_idx), bus.colisao_max_y, bus.colisao_min_y,
            bus.colisao_max_x, bus.colisao_min_x};
  endfunction

  function automatic logic [9:0] obs1();
    return {6'(bus1.hit_idx), bus1.colisao_max_y, bus1.colisao_min_y,
            bus1.colisao_max_x, bus1.colisao_min_x};
  endfunction

  // Called 1 time unit after a rising edge with DUT idle.
  // lat = edges from accept to done, -1 on timeout.
  task automatic run_scan(input int x, input int y, input int t,
                          output int lat);
    bus.xPos = 10'(x);
    bus.yPos = 9'(y);
    bus.tamanho = 7'(t);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    if (!bus.done) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic run_scan1(input int x, input int y, input int t,
                           output int lat);
    bus1.xPos = 10'(x);
    bus1.yPos = 9'(y);
    bus1.tamanho = 7'(t);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus1.done) break;
    end
    if (!bus1.done) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.busy, bus.done, obs0()};
    nvec++;
    if (got !== 12'h0) begin
      nerr++;
      $display("FAIL reset_state got %h want 000", got);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int xs [5] = '{200, 200, 200, 0, 630};
    int ys [5] = '{90, 89, 91, 0, 0};
    // bit index to check and its required value
    int bi [5] = '{3, 3, 3, 0, 1};
    logic bv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    logic [9:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      run_scan(xs[i], ys[i], 10, lat);
      got = obs0();
      exp = model(10, xs[i], ys[i], 10);
      nvec++;
      if (lat != 11) begin
        nerr++;
        $display("FAIL directed_lat[%0d] got %0d want 11", i, lat);
      end
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL directed[%0d] got %h want %h", i, got, exp);
      end
      nvec++;
      if (got[bi[i]] !== bv[i]) begin
        nerr++;
        $display("FAIL directed_bit[%0d] got %b want %b",
                 i, got[bi[i]], bv[i]);
      end
    end
    // origin case: both min flags, no max_x, no hit
    run_scan(0, 0, 10, lat);
    got = obs0();
    nvec++;
    if (got !== 10'b0000000101) begin
      nerr++;
      $display("FAIL origin got %h want 005", got);
    end
    // strict-boundary y=90 case: down only, hit 0
    run_scan(200, 90, 10, lat);
    got = obs0();
    nvec++;
    if (got !== 10'b0000001000) begin
      nerr++;
      $display("FAIL touch_down got %h want 008", got);
    end
  endtask

  task automatic test_latch();
    int lat, ndone;
    logic [9:0] got, exp;
    bus.xPos = 10'd200;
    bus.yPos = 9'd90;
    bus.tamanho = 7'd10;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.xPos = 10'd0;
    bus.yPos = 9'd0;
    bus.tamanho = 7'd0;
    ndone = 0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) begin
        bus.xPos = 10'd630;
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          got = obs0();
        end
      end
    end
    exp = model(10, 200, 90, 10);
    nvec++;
    if (lat != 11) begin
      nerr++;
      $display("FAIL latch_lat got %0d want 11", lat);
    end
    nvec++;
    if (ndone != 1) begin
      nerr++;
      $display("FAIL single_done got %0d want 1", ndone);
    end
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL latched got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat, ndone;
    logic [11:0] got;
    logic [9:0] r, exp;
    run_scan(630, 0, 10, lat);
    bus.xPos = 10'd0;
    bus.yPos = 9'd0;
    bus.tamanho = 7'd10;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got = {bus.busy, bus.done, obs0()};
    nvec++;
    if (got !== 12'h0) begin
      nerr++;
      $display("FAIL reset_mid got %h want 000", got);
    end
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    nvec++;
    if (ndone != 0) begin
      nerr++;
      $display("FAIL abandoned_done got %0d want 0", ndone);
    end
    run_scan(0, 0, 10, lat);
    r = obs0();
    exp = model(10, 0, 0, 10);
    nvec++;
    if (lat != 11 || r !== exp) begin
      nerr++;
      $display("FAIL after_reset got lat %0d res %h want 11 %h",
               lat, r, exp);
    end
  endtask

  task automatic test_multi_hit();
    int lat;
    logic [9:0] got;
    run_scan(52, 318, 4, lat);
    got = obs0();
    nvec++;
    if (got[9:4] !== 6'd3) begin
      nerr++;
      $display("FAIL multi_hit got %0d want 3", got[9:4]);
    end
    nvec++;
    if (got !== model(10, 52, 318, 4)) begin
      nerr++;
      $display("FAIL multi_flags got %h want %h",
               got, model(10, 52, 318, 4));
    end
    // zero-size object: only edge rules matter
    run_scan(200, 100, 0, lat);
    got = obs0();
    nvec++;
    if (got !== 10'h0) begin
      nerr++;
      $display("FAIL zero_size got %h want 000", got);
    end
  endtask

  task automatic test_random();
    int lat, k, x, y, t;
    logic [9:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 511));
        t = int'($urandom_range(0, 127));
      end else begin
        k = int'($urandom_range(0, 9));
        t = int'($urandom_range(0, 20));
        x = OX0[k] - t - 2 +
            int'($urandom_range(0, OX1[k] - OX0[k] + t + 4));
        y = OY0[k] - t - 2 +
            int'($urandom_range(0, OY1[k] - OY0[k] + t + 4));
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (y > 511) y = 511;
      end
      run_scan(x, y, t, lat);
      got = obs0();
      exp = model(10, x, y, t);
      nvec++;
      if (lat != 11 || got !== exp) begin
        nerr++;
        $display("FAIL rand[%0d] x%0d y%0d t%0d got %0d %h want 11 %h",
                 i, x, y, t, lat, got, exp);
      end
    end
  endtask

  task automatic test_n1();
    int lat;
    logic [9:0] got, exp;
    run_scan1(200, 90, 10, lat);
    got = obs1();
    exp = model(1, 200, 90, 10);
    nvec++;
    if (lat != 2) begin
      nerr++;
      $display("FAIL n1_lat got %0d want 2", lat);
    end
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL n1_res got %h want %h", got, exp);
    end
    run_scan1(52, 318, 4, lat);
    got = obs1();
    nvec++;
    if (got !== 10'h0) begin
      nerr++;
      $display("FAIL n1_outside got %h want 000", got);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.xPos = '0;
    bus.yPos = '0;
    bus.tamanho = '0;
    bus1.start = 1'b0;
    bus1.xPos = '0;
    bus1.yPos = '0;
    bus1.tamanho = '0;
    #1;
    test_reset();
    test_directed();
    test_latch();
    test_reset_mid();
    test_multi_hit();
    test_random();
    test_n1();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
